mem_dma: RTL and testbench
==========================

Name: mem_dma

Overview:
- Block-transfer initiator that drives the single-port data memory (addr / st_data / write-enable, combinational ld_data) on behalf of a command interface.
- Performs word copy (src→dst) or constant fill (value→dst) without CPU involvement.
- Sits beside the core on the data-memory port; the core must not access memory while busy=1.
- Refuses to write the hard-wired low addresses (zero / ira / pc window).

Parameters:
- ADDR_W, 16, memory address width; all address arithmetic is modulo 2^ADDR_W.
- DATA_W, 16, memory word width.
- PROT_TOP, 2, highest protected address; writes to 0..PROT_TOP are suppressed.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_mode  in  1  0 = copy, 1 = fill.
- cmd_src  in  ADDR_W  copy source base address (ignored in fill).
- cmd_dst  in  ADDR_W  destination base address.
- cmd_len  in  ADDR_W  word count; 0 is legal.
- cmd_fill  in  DATA_W  fill value (ignored in copy).
- mem_addr  out  ADDR_W  memory address.
- mem_st_data  out  DATA_W  memory store data.
- mem_we  out  1  memory write strobe.
- mem_ld_data  in  DATA_W  memory load data, combinational from mem_addr.
- busy  out  1  transfer in progress (any state except IDLE).
- done  out  1  one-cycle pulse at end of command.
- err  out  1  at least one protected write was suppressed in the last command; sticky until the next accept.
- words_done  out  ADDR_W  words completed in the current or last command.

Behaviour:
- Reset (async assert, sync release): state=IDLE, cmd_ready=1, busy=0, done=0, err=0, words_done=0, mem_addr=0, mem_st_data=0, mem_we=0.
- Reset mid-transfer abandons the transfer immediately; no further memory writes occur.
- States: IDLE, RD, WR, DONE.
- IDLE outputs: mem_we=0, mem_addr=0, mem_st_data=0, cmd_ready=1.
- Accept: cmd_valid & cmd_ready at a rising edge.
  - Latch mode, src, dst, len, fill; clear err and words_done; set index i=0.
  - len=0: go to DONE.
  - Copy: go to RD.
  - Fill: go to WR.
- cmd_* inputs are don't-care outside the accept edge.
- RD (copy only): mem_addr=src+i, mem_we=0. At the edge, capture mem_ld_data into the word buffer; go to WR.
- WR:
  - mem_addr=dst+i; mem_st_data = buffer (copy) or fill value (fill).
  - mem_we=1 unless (dst+i) mod 2^ADDR_W ≤ PROT_TOP. In that case mem_we=0 and err is set at the edge.
  - At the edge: i++, words_done++. If i+1==len go to DONE; else copy → RD, fill → WR.
- DONE: done=1 for exactly one cycle, busy=1, mem_we=0; next state is IDLE.
- Timing for len=N>0:
  - Copy uses 2N access cycles; fill uses N.
  - done is high in the cycle after the last WR.
  - cmd_ready returns the cycle after done.
- Address wrap: src+i and dst+i wrap from 0xFFFF to 0x0000. The wrapped destination is subject to the protection check.
- Overlap: strictly ascending word-by-word order. With dst>src overlapping, already-written words are re-read (defined, not corrected).
- Suppressed writes still count in words_done.
- A command arriving while busy is not accepted; the requester holds cmd_valid.

Test Plan:
- Copy len=4, src=0x0100 holding 0x1111,0x2222,0x3333,0x4444, dst=0x0200 → 8 alternating RD/WR cycles; mem 0x0200..0x0203 = source; done one cycle after last WR; words_done=4; err=0.
- Fill len=3, dst=0x0010, fill=0xBEEF → mem_we=1 for 3 consecutive cycles at 0x10,0x11,0x12; done next cycle; cmd_ready high the cycle after.
- Fill len=5, dst=0x0000, fill=0xAAAA → no writes at 0..2; writes at 3,4; err=1; words_done=5.
- Copy len=2, src=0xFFFF, dst=0xFFFE → reads 0xFFFF then 0x0000; writes 0xFFFE then 0xFFFF; no protection hit; err=0.
- len=0 with cmd_valid → busy for 1 cycle (DONE), done pulse, zero mem_we cycles; a second cmd_valid held during busy is accepted only after cmd_ready returns.
- rst_n low during the 3rd WR of a fill len=8 → mem_we=0 immediately; all outputs at reset values; a subsequent fill len=1 runs normally; err cleared.

Source files
------------

// File: rtl/mem_dma.sv
// Block-transfer engine on the data-memory port: word copy (src -> dst) or constant fill.
// Writes that land on the hard-wired low window (0..PROT_TOP) are dropped and flagged in err.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a command, memory port quiet, cmd_ready high
// RD     | copy only: present src+i, capture load data into the buffer
// WR     | present dst+i with buffer/fill data, strobe unless protected
// DONE   | one-cycle done pulse, then back to IDLE
module mem_dma #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int PROT_TOP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] cmd_fill,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_st_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_ld_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] words_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic              MODE_FILL = 1'b1;
    localparam logic [ADDR_W-1:0] PROT_ADDR = ADDR_W'(PROT_TOP);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    state_t state_q;
    state_t state_d;

    logic              mode_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] len_q;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] buf_q;
    logic [ADDR_W-1:0] idx_q;
    logic              err_q;

    logic              accept;
    logic              last_word;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_prot;

    // Address sums wrap naturally at ADDR_W bits; the wrapped destination is what gets checked.
    assign rd_addr   = src_q + idx_q;
    assign wr_addr   = dst_q + idx_q;
    assign wr_prot   = (wr_addr <= PROT_ADDR);
    assign last_word = ((idx_q + ONE) == len_q);
    assign accept    = cmd_valid && (state_q == S_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        state_d = S_DONE;
                    end else if (cmd_mode == MODE_FILL) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                state_d = S_WR;
            end
            S_WR: begin
                if (last_word) begin
                    state_d = S_DONE;
                end else if (mode_q == MODE_FILL) begin
                    state_d = S_WR;
                end else begin
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        mem_addr    = '0;
        mem_st_data = '0;
        mem_we      = 1'b0;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_RD: begin
                mem_addr = rd_addr;
            end
            S_WR: begin
                mem_addr    = wr_addr;
                mem_st_data = (mode_q == MODE_FILL) ? fill_q : buf_q;
                mem_we      = !wr_prot;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Command latch and transfer datapath; idx_q doubles as the words_done count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            fill_q <= '0;
            buf_q  <= '0;
            idx_q  <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            mode_q <= cmd_mode;
            src_q  <= cmd_src;
            dst_q  <= cmd_dst;
            len_q  <= cmd_len;
            fill_q <= cmd_fill;
            idx_q  <= '0;
            err_q  <= 1'b0;
        end else if (state_q == S_RD) begin
            buf_q <= mem_ld_data;
        end else if (state_q == S_WR) begin
            idx_q <= idx_q + ONE;
            if (wr_prot) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err        = err_q;
    assign words_done = idx_q;

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma: cycle-by-cycle checks of copy, fill, protection, wrap,
// zero-length commands, busy back-pressure and mid-transfer reset against a behavioural memory.
module tb_mem_dma;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_mode;
    logic [15:0] cmd_src;
    logic [15:0] cmd_dst;
    logic [15:0] cmd_len;
    logic [15:0] cmd_fill;
    logic [15:0] mem_addr;
    logic [15:0] mem_st_data;
    logic        mem_we;
    logic [15:0] mem_ld_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_done;

    logic [15:0] mem [0:65535];
    int          we_count;
    int          n_cmp;
    int          n_fail;

    localparam logic [15:0] CP_DATA [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    mem_dma #(.ADDR_W(16), .DATA_W(16), .PROT_TOP(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_mode    (cmd_mode),
        .cmd_src     (cmd_src),
        .cmd_dst     (cmd_dst),
        .cmd_len     (cmd_len),
        .cmd_fill    (cmd_fill),
        .mem_addr    (mem_addr),
        .mem_st_data (mem_st_data),
        .mem_we      (mem_we),
        .mem_ld_data (mem_ld_data),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .words_done  (words_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ld_data = mem[mem_addr];

    initial we_count = 0;
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_st_data;
            we_count      <= we_count + 1;
        end
    end

    task automatic issue(input logic mode, input logic [15:0] src, input logic [15:0] dst,
                         input logic [15:0] len, input logic [15:0] fill);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready: got %b want 1", cmd_ready);
        end
        cmd_mode  = mode;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_len   = len;
        cmd_fill  = fill;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({cmd_ready, busy, done, err, mem_we} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 10000", {cmd_ready, busy, done, err, mem_we});
        end
        n_cmp++;
        if ({words_done, mem_addr, mem_st_data} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_buses: got %h want 0", {words_done, mem_addr, mem_st_data});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_copy();
        for (int k = 0; k < 4; k++) mem[16'h0100 + 16'(k)] <= CP_DATA[k];
        for (int k = 0; k < 4; k++) mem[16'h0200 + 16'(k)] <= 16'h0000;
        @(negedge clk);
        issue(1'b0, 16'h0100, 16'h0200, 16'd4, 16'hDEAD);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({busy, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0100 + 16'(k)}) begin
                n_fail++;
                $display("FAIL copy_rd k=%0d: got %h want %h", k, {busy, mem_we, mem_addr},
                         {1'b1, 1'b0, 16'h0100 + 16'(k)});
            end
            @(negedge clk);
            n_cmp++;
            if ({mem_we, mem_addr, mem_st_data} !== {1'b1, 16'h0200 + 16'(k), CP_DATA[k]}) begin
                n_fail++;
                $display("FAIL copy_wr k=%0d: got %h want %h", k, {mem_we, mem_addr, mem_st_data},
                         {1'b1, 16'h0200 + 16'(k), CP_DATA[k]});
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({done, busy, mem_we} !== 3'b110) begin
            n_fail++;
            $display("FAIL copy_done: got %b want 110", {done, busy, mem_we});
        end
        @(negedge clk);
        n_cmp++;
        if ({done, busy, cmd_ready, err, words_done} !== {4'b0010, 16'd4}) begin
            n_fail++;
            $display("FAIL copy_end: got %h want %h", {done, busy, cmd_ready, err, words_done},
                     {4'b0010, 16'd4});
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (mem[16'h0200 + 16'(k)] !== CP_DATA[k]) begin
                n_fail++;
                $display("FAIL copy_mem k=%0d: got %h want %h", k, mem[16'h0200 + 16'(k)], CP_DATA[k]);
            end
        end
    endtask

    task automatic test_fill();
        issue(1'b1, 16'h7777, 16'h0010, 16'd3, 16'hBEEF);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({mem_we, mem_addr, mem_st_data} !== {1'b1, 16'h0010 + 16'(k), 16'hBEEF}) begin
                n_fail++;
                $display("FAIL fill_wr k=%0d: got %h want %h", k, {mem_we, mem_addr, mem_st_data},
                         {1'b1, 16'h0010 + 16'(k), 16'hBEEF});
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({done, busy, mem_we, cmd_ready} !== 4'b1100) begin
            n_fail++;
            $display("FAIL fill_done: got %b want 1100", {done, busy, mem_we, cmd_ready});
        end
        @(negedge clk);
        n_cmp++;
        if ({done, cmd_ready, err, words_done} !== {3'b010, 16'd3}) begin
            n_fail++;
            $display("FAIL fill_end: got %h want %h", {done, cmd_ready, err, words_done}, {3'b010, 16'd3});
        end
    endtask

    task automatic test_fill_protected();
        for (int k = 0; k < 3; k++) mem[16'(k)] <= 16'h5555;
        mem[16'h0003] <= 16'h0000;
        mem[16'h0004] <= 16'h0000;
        @(negedge clk);
        issue(1'b1, 16'h0000, 16'h0000, 16'd5, 16'hAAAA);
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if ({mem_we, mem_addr, mem_st_data} !== {(k >= 3), 16'(k), 16'hAAAA}) begin
                n_fail++;
                $display("FAIL prot_wr k=%0d: got %h want %h", k, {mem_we, mem_addr, mem_st_data},
                         {(k >= 3), 16'(k), 16'hAAAA});
            end
            @(negedge clk);
        end
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, err, words_done} !== {2'b11, 16'd5}) begin
            n_fail++;
            $display("FAIL prot_end: got %h want %h", {cmd_ready, err, words_done}, {2'b11, 16'd5});
        end
        n_cmp++;
        if ({mem[0], mem[1], mem[2], mem[3], mem[4]} !==
            {16'h5555, 16'h5555, 16'h5555, 16'hAAAA, 16'hAAAA}) begin
            n_fail++;
            $display("FAIL prot_mem: got %h want 5555_5555_5555_aaaa_aaaa",
                     {mem[0], mem[1], mem[2], mem[3], mem[4]});
        end
    endtask

    task automatic test_copy_wrap();
        mem[16'hFFFF] <= 16'h1234;
        mem[16'h0000] <= 16'h5678;
        mem[16'hFFFE] <= 16'h0000;
        @(negedge clk);
        issue(1'b0, 16'hFFFF, 16'hFFFE, 16'd2, 16'h0000);
        n_cmp++;
        if ({mem_we, mem_addr} !== {1'b0, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL wrap_rd0: got %h want %h", {mem_we, mem_addr}, {1'b0, 16'hFFFF});
        end
        @(negedge clk);
        n_cmp++;
        if ({mem_we, mem_addr, mem_st_data} !== {1'b1, 16'hFFFE, 16'h1234}) begin
            n_fail++;
            $display("FAIL wrap_wr0: got %h want %h", {mem_we, mem_addr, mem_st_data}, {1'b1, 16'hFFFE, 16'h1234});
        end
        @(negedge clk);
        n_cmp++;
        if ({mem_we, mem_addr} !== {1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL wrap_rd1: got %h want %h", {mem_we, mem_addr}, {1'b0, 16'h0000});
        end
        @(negedge clk);
        n_cmp++;
        if ({mem_we, mem_addr, mem_st_data} !== {1'b1, 16'hFFFF, 16'h5678}) begin
            n_fail++;
            $display("FAIL wrap_wr1: got %h want %h", {mem_we, mem_addr, mem_st_data}, {1'b1, 16'hFFFF, 16'h5678});
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({err, words_done, mem[16'hFFFE], mem[16'hFFFF]} !== {1'b0, 16'd2, 16'h1234, 16'h5678}) begin
            n_fail++;
            $display("FAIL wrap_end: got %h want %h", {err, words_done, mem[16'hFFFE], mem[16'hFFFF]},
                     {1'b0, 16'd2, 16'h1234, 16'h5678});
        end
    endtask

    task automatic test_len_zero_back_to_back();
        int wc;
        wc = we_count;
        issue(1'b1, 16'h0000, 16'h0050, 16'd0, 16'h9999);
        // Second command held from the DONE cycle onward; must wait for cmd_ready.
        cmd_mode  = 1'b1;
        cmd_dst   = 16'h0020;
        cmd_len   = 16'd1;
        cmd_fill  = 16'h0C0C;
        cmd_valid = 1'b1;
        n_cmp++;
        if ({done, busy, cmd_ready, mem_we} !== 4'b1100) begin
            n_fail++;
            $display("FAIL len0_done: got %b want 1100", {done, busy, cmd_ready, mem_we});
        end
        @(negedge clk);
        n_cmp++;
        if ({done, busy, cmd_ready, words_done} !== {3'b001, 16'd0}) begin
            n_fail++;
            $display("FAIL len0_idle: got %h want %h", {done, busy, cmd_ready, words_done}, {3'b001, 16'd0});
        end
        n_cmp++;
        if (we_count !== wc) begin
            n_fail++;
            $display("FAIL len0_writes: got %0d want %0d", we_count, wc);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_cmp++;
        if ({busy, mem_we, mem_addr, mem_st_data} !== {2'b11, 16'h0020, 16'h0C0C}) begin
            n_fail++;
            $display("FAIL b2b_wr: got %h want %h", {busy, mem_we, mem_addr, mem_st_data},
                     {2'b11, 16'h0020, 16'h0C0C});
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, words_done, mem[16'h0020]} !== {1'b1, 16'd1, 16'h0C0C}) begin
            n_fail++;
            $display("FAIL b2b_end: got %h want %h", {cmd_ready, words_done, mem[16'h0020]},
                     {1'b1, 16'd1, 16'h0C0C});
        end
    endtask

    task automatic test_reset_mid();
        int wc;
        issue(1'b1, 16'h0000, 16'h0001, 16'd8, 16'h7777);
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({mem_we, mem_addr, err} !== {1'b1, 16'h0003, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_wr3: got %h want %h", {mem_we, mem_addr, err}, {1'b1, 16'h0003, 1'b1});
        end
        wc    = we_count;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_we, busy, done, err, cmd_ready, words_done, mem_addr, mem_st_data} !==
            {5'b00001, 48'h0}) begin
            n_fail++;
            $display("FAIL mid_rst: got %h want %h",
                     {mem_we, busy, done, err, cmd_ready, words_done, mem_addr, mem_st_data}, {5'b00001, 48'h0});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if ({we_count, mem[16'h0003], mem[16'h0004]} !== {wc, 16'hAAAA, 16'hAAAA}) begin
            n_fail++;
            $display("FAIL mid_nowrite: got %h want %h", {we_count, mem[16'h0003], mem[16'h0004]},
                     {wc, 16'hAAAA, 16'hAAAA});
        end
        @(negedge clk);
        issue(1'b1, 16'h0000, 16'h0030, 16'd1, 16'h1357);
        n_cmp++;
        if ({mem_we, mem_addr, mem_st_data} !== {1'b1, 16'h0030, 16'h1357}) begin
            n_fail++;
            $display("FAIL post_wr: got %h want %h", {mem_we, mem_addr, mem_st_data}, {1'b1, 16'h0030, 16'h1357});
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL post_done: got %b want 1", done);
        end
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, err, words_done, mem[16'h0030]} !== {2'b10, 16'd1, 16'h1357}) begin
            n_fail++;
            $display("FAIL post_end: got %h want %h", {cmd_ready, err, words_done, mem[16'h0030]},
                     {2'b10, 16'd1, 16'h1357});
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode  = 1'b0;
        cmd_src   = '0;
        cmd_dst   = '0;
        cmd_len   = '0;
        cmd_fill  = '0;
        test_reset();
        test_copy();
        test_fill();
        test_fill_protected();
        test_copy_wrap();
        test_len_zero_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
